// File: rtl/sa22_if.sv
// ---------------------------------------------------------------------------
// sa22_if -- signal bundle between a job source / 2x2 systolic array and the
// sa22_ctrl controller.
//
// Job side    : start, num_vec, w11..w22 (into controller)
// Vector side : act_valid, act_a1, act_a2 (in), act_ready (out)
// Array side  : weight_en, weight_in11/12, activation_in11/21,
//               partial_sum_in11/12 (out), reg_partial_sum21/22 (in)
// Result side : res_valid, res0, res1, busy, done (out)
//
// modport slave  : the controller
// modport master : whatever drives jobs and models the array
// ---------------------------------------------------------------------------
interface sa22_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic                 start;
    logic [CW-1:0]        num_vec;
    logic signed [DW-1:0] w11;
    logic signed [DW-1:0] w12;
    logic signed [DW-1:0] w21;
    logic signed [DW-1:0] w22;
    logic                 act_valid;
    logic signed [DW-1:0] act_a1;
    logic signed [DW-1:0] act_a2;
    logic                 act_ready;
    logic                 weight_en;
    logic signed [DW-1:0] weight_in11;
    logic signed [DW-1:0] weight_in12;
    logic signed [DW-1:0] activation_in11;
    logic signed [DW-1:0] activation_in21;
    logic signed [DW-1:0] partial_sum_in11;
    logic signed [DW-1:0] partial_sum_in12;
    logic signed [DW-1:0] reg_partial_sum21;
    logic signed [DW-1:0] reg_partial_sum22;
    logic                 res_valid;
    logic signed [DW-1:0] res0;
    logic signed [DW-1:0] res1;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, num_vec, w11, w12, w21, w22,
        input  act_valid, act_a1, act_a2,
        input  reg_partial_sum21, reg_partial_sum22,
        output act_ready, weight_en, weight_in11, weight_in12,
        output activation_in11, activation_in21,
        output partial_sum_in11, partial_sum_in12,
        output res_valid, res0, res1, busy, done
    );

    modport master (
        output start, num_vec, w11, w12, w21, w22,
        output act_valid, act_a1, act_a2,
        output reg_partial_sum21, reg_partial_sum22,
        input  act_ready, weight_en, weight_in11, weight_in12,
        input  activation_in11, activation_in21,
        input  partial_sum_in11, partial_sum_in12,
        input  res_valid, res0, res1, busy, done
    );
endinterface

// File: rtl/sa22_ctrl.sv
// ---------------------------------------------------------------------------
// sa22_ctrl -- job controller for a 2x2 weight-stationary systolic array.
//
// Loads the 2x2 weight matrix (bottom row first so it shifts down into place),
// streams num_vec activation vectors into the left edge with a one-cycle row
// skew, then collects and deskews the two bottom-edge column sums into one
// result vector per accepted activation vector.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : sa22_if.slave (job, vector handshake, array feeds, results, status)
// ---------------------------------------------------------------------------
module sa22_ctrl #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic   clk,
    input  logic   rst,
    sa22_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD0  = 3'd1,
        S_LOAD1  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // latched job parameters
    logic [CW-1:0]        num_vec_q;
    logic [CW-1:0]        cnt_q;
    logic signed [DW-1:0] w11_q, w12_q, w21_q, w22_q;

    // activation feed and result deskew registers
    logic signed [DW-1:0] act11_q;
    logic signed [DW-1:0] a2_hold_q;
    logic signed [DW-1:0] act21_q;
    logic signed [DW-1:0] col0_q;
    logic signed [DW-1:0] col0_dly_q;
    logic signed [DW-1:0] col1_q;

    // vld_q[k] is set while the vector whose row-1 slot was k cycles ago is in flight
    logic [4:0] vld_q, vld_d;

    logic                 start_ok;
    logic                 accept;
    logic                 last_accept;
    logic                 act_ready;
    logic                 weight_en;
    logic signed [DW-1:0] weight_in11;
    logic signed [DW-1:0] weight_in12;
    logic                 busy;
    logic                 done;

    assign start_ok    = (state_q == S_IDLE) && bus.start;
    assign accept      = bus.act_valid && act_ready;
    assign last_accept = accept && ((cnt_q + CW'(1)) == num_vec_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD0;
            S_LOAD0:  state_d = S_LOAD1;
            S_LOAD1:  state_d = (num_vec_q == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (last_accept) state_d = S_DRAIN;
            // vld_q[4] is the res_valid being issued now; once nothing is
            // behind it the job is complete after this cycle
            S_DRAIN:  if (vld_q[3:0] == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        weight_en   = 1'b0;
        weight_in11 = '0;
        weight_in12 = '0;
        act_ready   = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        case (state_q)
            // bottom row goes in first; the second load pushes it down a row
            S_LOAD0: begin
                weight_en   = 1'b1;
                weight_in11 = w21_q;
                weight_in12 = w22_q;
            end
            S_LOAD1: begin
                weight_en   = 1'b1;
                weight_in11 = w11_q;
                weight_in12 = w12_q;
            end
            S_STREAM: act_ready = (cnt_q < num_vec_q);
            default: ;
        endcase
    end

    // ---------------- valid pipeline ----------------
    assign vld_d[0] = accept;
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_vld
            assign vld_d[gi] = vld_q[gi-1];
        end
    endgenerate

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_vec_q  <= '0;
            cnt_q      <= '0;
            w11_q      <= '0;
            w12_q      <= '0;
            w21_q      <= '0;
            w22_q      <= '0;
            act11_q    <= '0;
            a2_hold_q  <= '0;
            act21_q    <= '0;
            col0_q     <= '0;
            col0_dly_q <= '0;
            col1_q     <= '0;
            vld_q      <= '0;
        end else begin
            if (start_ok) begin
                num_vec_q <= bus.num_vec;
                w11_q     <= bus.w11;
                w12_q     <= bus.w12;
                w21_q     <= bus.w21;
                w22_q     <= bus.w22;
                cnt_q     <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // bubbles feed zeros; row 2 trails row 1 by one cycle
            act11_q   <= accept ? bus.act_a1 : '0;
            a2_hold_q <= accept ? bus.act_a2 : '0;
            act21_q   <= a2_hold_q;

            vld_q <= vld_d;

            // column 0 settles one cycle before column 1, so it is held one
            // extra register to line both up with res_valid
            if (vld_q[2]) col0_q <= bus.reg_partial_sum21;
            col0_dly_q <= col0_q;
            if (vld_q[3]) col1_q <= bus.reg_partial_sum22;
        end
    end

    assign bus.act_ready        = act_ready;
    assign bus.weight_en        = weight_en;
    assign bus.weight_in11      = weight_in11;
    assign bus.weight_in12      = weight_in12;
    assign bus.activation_in11  = act11_q;
    assign bus.activation_in21  = act21_q;
    assign bus.partial_sum_in11 = '0;
    assign bus.partial_sum_in12 = '0;
    assign bus.res_valid        = vld_q[4];
    assign bus.res0             = vld_q[4] ? col0_dly_q : '0;
    assign bus.res1             = vld_q[4] ? col1_q : '0;
    assign bus.busy             = busy;
    assign bus.done             = done;

endmodule

// File: tb/tb_sa22_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sa22_ctrl -- self-checking bench for sa22_ctrl.
// A behavioural 2x2 array model answers the controller's feeds; a driver
// issues jobs and pushes expected result vectors (matrix-vector products with
// DW-bit wrap) into a scoreboard; a monitor pops and compares on res_valid.
// ---------------------------------------------------------------------------
module tb_sa22_ctrl;
    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa22_if #(.DW(DW), .CW(CW)) bus ();

    sa22_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [DW-1:0] r0;
        logic signed [DW-1:0] r1;
        int                   t;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int nres   = 0;

    logic signed [DW-1:0] va1[$];
    logic signed [DW-1:0] va2[$];
    bit                   pat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // two products summed, wrapped to DW bits
    function automatic logic signed [DW-1:0] mac(input logic signed [DW-1:0] wa, aa, wb, ab);
        longint r;
        r = longint'(wa) * longint'(aa) + longint'(wb) * longint'(ab);
        return r[DW-1:0];
    endfunction

    // ---------------- behavioural 2x2 array ----------------
    logic signed [DW-1:0] aw11 = '0, aw12 = '0, aw21 = '0, aw22 = '0;
    logic signed [DW-1:0] h11[4];
    logic signed [DW-1:0] h21[3];

    initial begin
        for (int i = 0; i < 4; i++) h11[i] = '0;
        for (int i = 0; i < 3; i++) h21[i] = '0;
        bus.reg_partial_sum21 = '0;
        bus.reg_partial_sum22 = '0;
        forever begin
            @(negedge clk);
            if (bus.weight_en) begin
                aw21 = aw11; aw22 = aw12;
                aw11 = bus.weight_in11; aw12 = bus.weight_in12;
            end
            for (int i = 3; i > 0; i--) h11[i] = h11[i-1];
            h11[0] = bus.activation_in11;
            for (int i = 2; i > 0; i--) h21[i] = h21[i-1];
            h21[0] = bus.activation_in21;
            bus.reg_partial_sum21 = mac(aw11, h11[2], aw21, h21[1]);
            bus.reg_partial_sum22 = mac(aw12, h11[3], aw22, h21[2]);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                nres++;
                $display("RES cyc=%0d res0=%0d res1=%0d", cyc, bus.res0, bus.res1);
                chk("res_has_expected", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res0", bus.res0, e.r0);
                    chk("res1", bus.res1, e.r1);
                    chk("res_latency", cyc, e.t + 5);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic push_vec(input int a, input int b);
        va1.push_back(DW'(a));
        va2.push_back(DW'(b));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.act_ready, bus.weight_en, bus.res_valid, bus.busy, bus.done}, 0);
        chk({tag, "_data"}, bus.weight_in11 | bus.weight_in12 | bus.activation_in11 |
            bus.activation_in21 | bus.res0 | bus.res1 | bus.partial_sum_in11 | bus.partial_sum_in12, 0);
    endtask

    task automatic run_job(input string tag, input logic signed [DW-1:0] w11, w12, w21, w22,
                           input int nv, input bit abort);
        int  idx, pi, guard, n0;
        bit  seen_done;
        n0 = nres;
        @(negedge clk);
        bus.start = 1'b1; bus.num_vec = CW'(nv);
        bus.w11 = w11; bus.w12 = w12; bus.w21 = w21; bus.w22 = w22;
        $display("JOB %s nv=%0d W=[[%0d,%0d],[%0d,%0d]]", tag, nv, w11, w12, w21, w22);
        @(negedge clk);
        // scramble job inputs: the controller must use its latched copies
        bus.start = 1'b0; bus.num_vec = CW'($urandom);
        bus.w11 = DW'($urandom); bus.w12 = DW'($urandom);
        bus.w21 = DW'($urandom); bus.w22 = DW'($urandom);
        chk("load0_en", bus.weight_en, 1);
        chk("load0_w11", bus.weight_in11, w21);
        chk("load0_w12", bus.weight_in12, w22);
        chk("load_busy", bus.busy, 1);
        @(negedge clk);
        chk("load1_en", bus.weight_en, 1);
        chk("load1_w11", bus.weight_in11, w11);
        chk("load1_w12", bus.weight_in12, w12);
        idx = 0; pi = 0; guard = 0;
        while (idx < nv && guard < 400) begin
            @(negedge clk);
            guard++;
            bus.act_valid = (pi < pat.size()) ? pat[pi] : 1'($urandom_range(0, 1));
            pi++;
            bus.act_a1 = bus.act_valid ? va1[idx] : DW'($urandom);
            bus.act_a2 = bus.act_valid ? va2[idx] : DW'($urandom);
            chk("stream_ready", bus.act_ready, 1);
            chk("stream_wen", bus.weight_en, 0);
            if (bus.act_valid && bus.act_ready) begin
                sb.push_back('{mac(w11, va1[idx], w21, va2[idx]),
                               mac(w12, va1[idx], w22, va2[idx]), cyc});
                $display("ACC cyc=%0d a1=%0d a2=%0d", cyc, va1[idx], va2[idx]);
                idx++;
                if (abort) break;
            end
        end
        chk("stream_accepted", idx, abort ? 1 : nv);

        if (abort) begin
            @(negedge clk);
            rst = 1'b0; bus.act_valid = 1'b0;
            #1;
            chk_zero("abort_rst");
            sb.delete();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("abort_no_done", bus.done, 0);
                chk("abort_idle", bus.busy, 0);
            end
        end else begin
            seen_done = 1'b0;
            for (int k = 0; k < 60 && !seen_done; k++) begin
                @(negedge clk);
                // a start while busy must be ignored
                bus.start     = (k == 0);
                bus.num_vec   = CW'($urandom_range(1, 9));
                bus.act_valid = 1'($urandom_range(0, 1));
                bus.act_a1    = DW'($urandom);
                bus.act_a2    = DW'($urandom);
                if (bus.done) seen_done = 1'b1;
                else begin
                    chk("drain_ready", bus.act_ready, 0);
                    chk("drain_busy", bus.busy, 1);
                end
            end
            chk("done_seen", seen_done, 1);
            chk("sb_empty_at_done", sb.size(), 0);
            chk("result_count", nres - n0, nv);
            @(negedge clk);
            bus.start = 1'b0; bus.act_valid = 1'b0;
            chk("done_single", bus.done, 0);
            chk("idle_after_done", bus.busy, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("stay_idle", bus.busy, 0);
            end
        end
        va1.delete(); va2.delete(); pat.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0; bus.num_vec = '0;
        bus.w11 = '0; bus.w12 = '0; bus.w21 = '0; bus.w22 = '0;
        bus.act_valid = 1'b0; bus.act_a1 = '0; bus.act_a2 = '0;
        #1 rst = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        push_vec(5, 6); pat = '{1'b1};
        run_job("basic", 1, 2, 3, 4, 1, 1'b0);

        push_vec(1, 0); push_vec(0, 1); push_vec(-2, 3); pat = '{1'b1, 1'b1, 1'b1};
        run_job("b2b", 1, 2, 3, 4, 3, 1'b0);

        push_vec($urandom_range(0, 99), $urandom_range(0, 99));
        push_vec($urandom_range(0, 99), $urandom_range(0, 99));
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job("gap", 1, 2, 3, 4, 2, 1'b0);

        run_job("empty", 7, 8, 9, 10, 0, 1'b0);

        push_vec(1, 1); pat = '{1'b1};
        run_job("wrap", 32767, 0, 1, 0, 1, 1'b0);

        push_vec(11, 12); push_vec(13, 14); push_vec(15, 16); pat = '{1'b1};
        run_job("abort", 1, 2, 3, 4, 3, 1'b1);

        push_vec(5, 6); push_vec(-3, 2); pat = '{1'b1, 1'b1};
        run_job("after_rst", 1, 2, 3, 4, 2, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int nv;
            nv = $urandom_range(1, 6);
            for (int i = 0; i < nv; i++) push_vec(int'($urandom), int'($urandom));
            run_job("random", DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), nv, 1'b0);
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sa22_ctrl.md
SA22_CTRL -- requirements
Module: sa22_ctrl

Interface
REQ-001 Parameter: DW, default 16, width of weight, activation and partial-sum data.
REQ-002 Parameter: CW, default 8, width of the vector-count input.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run a job; sampled only in IDLE.
REQ-006 num_vec  input  CW  number of activation vectors in the job; latched on accepted start.
REQ-007 w11, w12, w21, w22  input  DW each  signed weight matrix (row,col); latched on accepted start.
REQ-008 act_valid  input  1  activation vector offered.
REQ-009 act_a1, act_a2  input  DW each  signed activation vector elements for array rows 1 and 2.
REQ-010 act_ready  output  1  controller accepts the vector this cycle.
REQ-011 weight_en  output  1  array weight-load enable.
REQ-012 weight_in11, weight_in12  output  DW each  top-edge weight feed.
REQ-013 activation_in11, activation_in21  output  DW each  left-edge activation feed.
REQ-014 partial_sum_in11, partial_sum_in12  output  DW each  top-edge partial-sum feed.
REQ-015 reg_partial_sum21, reg_partial_sum22  input  DW each  bottom-edge sums returned by the array.
REQ-016 res_valid  output  1  one deskewed result vector is presented.
REQ-017 res0, res1  output  DW each  signed column-0 and column-1 results.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse at job completion.

Function
REQ-020 States SHALL be IDLE, LOAD0, LOAD1, STREAM, DRAIN and DONE.
REQ-021 IDLE->LOAD0 on start=1; start in any other state SHALL be ignored.
REQ-022 LOAD0 (1 cycle) SHALL drive weight_en=1, weight_in11=w21 and weight_in12=w22.
REQ-023 LOAD1 (1 cycle) SHALL drive weight_en=1, weight_in11=w11 and weight_in12=w12, then go to STREAM; if num_vec=0 it SHALL go to DRAIN instead.
REQ-024 weight_en SHALL be 0 in every state except LOAD0 and LOAD1; weight_in11/12 SHALL be 0 when weight_en=0.
REQ-025 partial_sum_in11 and partial_sum_in12 SHALL be constant 0.
REQ-026 act_ready SHALL be 1 only in STREAM while the accepted count is below num_vec; a vector is accepted when act_valid and act_ready are both 1.
REQ-027 For a vector accepted in cycle t: activation_in11=act_a1 in cycle t+1, and activation_in21=act_a2 in cycle t+2 (one-cycle row skew).
REQ-028 In cycles with no accepted vector, the corresponding activation feeds SHALL be 0 (bubble).
REQ-029 A valid bit SHALL travel with each vector through a shift pipeline; bubbles SHALL produce no result.
REQ-030 For a vector whose activation_in11 slot is cycle s, reg_partial_sum21 SHALL be sampled at s+2 and reg_partial_sum22 at s+3.
REQ-031 res0/res1 SHALL be presented together with res_valid=1 in cycle s+4: the column-0 sample delayed one extra register, the column-1 sample registered.
REQ-032 Results SHALL appear in acceptance order; there is no result backpressure.
REQ-033 Arithmetic SHALL be DW-bit two's complement, with wrap-around identical to the array.
REQ-034 STREAM->DRAIN in the cycle the num_vec-th vector is accepted.
REQ-035 DRAIN->DONE once the valid pipeline is empty and the last res_valid has been issued.
REQ-036 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; busy SHALL be 0 in that next cycle.
REQ-037 act_valid with no acceptance SHALL leave the pipeline unchanged apart from a bubble.

Reset
REQ-038 rst=0 SHALL immediately force state IDLE, clear counters and the valid pipeline, and drive all outputs to 0.
REQ-039 Reset mid-job SHALL abort the job with no done pulse and no further res_valid.
REQ-040 After rst returns to 1, the first start SHALL be accepted normally.

Verification
REQ-041 W=[[1,2],[3,4]], num_vec=1, vector (5,6) -> two weight_en cycles with feeds (3,4) then (1,2); one res_valid with res0=23 and res1=34; then a single done pulse.
REQ-042 Same W, num_vec=3, vectors (1,0),(0,1),(-2,3) back-to-back -> results in order (1,2),(3,4),(7,8) on consecutive res_valid cycles.
REQ-043 act_valid toggled 1,0,0,1 with num_vec=2 -> exactly 2 results, spaced by the input gap, and no spurious res_valid.
REQ-044 num_vec=0 -> load cycles, then done with no res_valid; a start pulse during busy is ignored.
REQ-045 W=[[32767,0],[1,0]] with vector (1,1) -> res0=-32768 (wrap); res1=0.
REQ-046 rst=0 during STREAM -> all outputs 0 at once, no done pulse; a new start afterwards completes correctly.
